// File: rtl/alu_operand_stage.sv
`default_nettype none
// =============================================================================
// Module   : alu_operand_stage
// Brief    : D/X pipeline register for the TinyRV1 ALU. Bypasses operands from
//            X and W, interlocks on load-use, and handles stall/squash bubbles.
// Revision : 1.0  initial release
// =============================================================================
module alu_operand_stage #(
    parameter int NREG_BITS = 5,
    parameter int DW        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_val,
    input  logic [NREG_BITS-1:0] d_rs1_addr,
    input  logic [NREG_BITS-1:0] d_rs2_addr,
    input  logic                 d_rs1_en,
    input  logic                 d_rs2_en,
    input  logic [DW-1:0]        d_rs1_data,
    input  logic [DW-1:0]        d_rs2_data,
    input  logic [DW-1:0]        d_imm,
    input  logic                 d_imm_sel,
    input  logic                 d_alu_op,
    input  logic                 d_is_load,
    input  logic [NREG_BITS-1:0] d_rd_waddr,
    input  logic                 d_rd_wen,
    input  logic [DW-1:0]        x_result,
    input  logic                 w_val,
    input  logic [NREG_BITS-1:0] w_rd_waddr,
    input  logic                 w_rd_wen,
    input  logic [DW-1:0]        w_result,
    input  logic                 x_stall,
    input  logic                 squash,
    output logic                 d_stall,
    output logic                 x_val,
    output logic [DW-1:0]        x_in0,
    output logic [DW-1:0]        x_in1,
    output logic                 x_alu_op,
    output logic [DW-1:0]        x_sdata,
    output logic [NREG_BITS-1:0] x_rd_waddr,
    output logic                 x_rd_wen,
    output logic                 x_is_load
);

    localparam logic [NREG_BITS-1:0] c_zero_addr = '0;

    logic                 x_val_q,      x_val_d;
    logic [DW-1:0]        x_in0_q,      x_in0_d;
    logic [DW-1:0]        x_in1_q,      x_in1_d;
    logic                 x_alu_op_q,   x_alu_op_d;
    logic [DW-1:0]        x_sdata_q,    x_sdata_d;
    logic [NREG_BITS-1:0] x_rd_waddr_q, x_rd_waddr_d;
    logic                 x_rd_wen_q,   x_rd_wen_d;
    logic                 x_is_load_q,  x_is_load_d;

    logic          w_x_fwd_ok;
    logic          w_w_fwd_ok;
    logic          w_rs1_x_hit;
    logic          w_rs1_w_hit;
    logic          w_rs2_x_hit;
    logic          w_rs2_w_hit;
    logic [DW-1:0] w_byp_rs1;
    logic [DW-1:0] w_byp_rs2;
    logic          w_load_use;

    // A load in X has no result yet; it can only be forwarded once it reaches W.
    assign w_x_fwd_ok  = x_val_q & x_rd_wen_q & ~x_is_load_q & (x_rd_waddr_q != c_zero_addr);
    assign w_w_fwd_ok  = w_val & w_rd_wen & (w_rd_waddr != c_zero_addr);

    assign w_rs1_x_hit = w_x_fwd_ok & (x_rd_waddr_q == d_rs1_addr);
    assign w_rs1_w_hit = w_w_fwd_ok & (w_rd_waddr   == d_rs1_addr);
    assign w_rs2_x_hit = w_x_fwd_ok & (x_rd_waddr_q == d_rs2_addr);
    assign w_rs2_w_hit = w_w_fwd_ok & (w_rd_waddr   == d_rs2_addr);

    assign w_byp_rs1 = w_rs1_x_hit ? x_result :
                       w_rs1_w_hit ? w_result : d_rs1_data;
    assign w_byp_rs2 = w_rs2_x_hit ? x_result :
                       w_rs2_w_hit ? w_result : d_rs2_data;

    assign w_load_use = d_val & x_val_q & x_is_load_q & x_rd_wen_q &
                        (x_rd_waddr_q != c_zero_addr) &
                        ((d_rs1_en & (d_rs1_addr == x_rd_waddr_q)) |
                         (d_rs2_en & (d_rs2_addr == x_rd_waddr_q)));

    // Squash outranks the interlock: a killed instruction has nothing to wait for.
    assign d_stall = x_stall | (~squash & w_load_use);

    always_comb begin
        x_val_d      = x_val_q;
        x_in0_d      = x_in0_q;
        x_in1_d      = x_in1_q;
        x_alu_op_d   = x_alu_op_q;
        x_sdata_d    = x_sdata_q;
        x_rd_waddr_d = x_rd_waddr_q;
        x_rd_wen_d   = x_rd_wen_q;
        x_is_load_d  = x_is_load_q;

        if (x_stall) begin
            x_val_d = x_val_q;
        end else if (squash || w_load_use) begin
            x_val_d     = 1'b0;
            x_rd_wen_d  = 1'b0;
            x_is_load_d = 1'b0;
        end else begin
            x_val_d      = d_val;
            x_in0_d      = w_byp_rs1;
            x_in1_d      = d_imm_sel ? d_imm : w_byp_rs2;
            x_alu_op_d   = d_alu_op;
            x_sdata_d    = w_byp_rs2;
            x_rd_waddr_d = d_rd_waddr;
            x_rd_wen_d   = d_val & d_rd_wen;
            x_is_load_d  = d_val & d_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_val_q      <= 1'b0;
            x_in0_q      <= '0;
            x_in1_q      <= '0;
            x_alu_op_q   <= 1'b0;
            x_sdata_q    <= '0;
            x_rd_waddr_q <= '0;
            x_rd_wen_q   <= 1'b0;
            x_is_load_q  <= 1'b0;
        end else begin
            x_val_q      <= x_val_d;
            x_in0_q      <= x_in0_d;
            x_in1_q      <= x_in1_d;
            x_alu_op_q   <= x_alu_op_d;
            x_sdata_q    <= x_sdata_d;
            x_rd_waddr_q <= x_rd_waddr_d;
            x_rd_wen_q   <= x_rd_wen_d;
            x_is_load_q  <= x_is_load_d;
        end
    end

    assign x_val      = x_val_q;
    assign x_in0      = x_in0_q;
    assign x_in1      = x_in1_q;
    assign x_alu_op   = x_alu_op_q;
    assign x_sdata    = x_sdata_q;
    assign x_rd_waddr = x_rd_waddr_q;
    assign x_rd_wen   = x_rd_wen_q;
    assign x_is_load  = x_is_load_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Self-checking bench for alu_operand_stage (directed table,
//            stall/reset sequences, randomized traffic vs. reference model).
// Revision : 1.0  initial release
// =============================================================================
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_val, d_rs1_en, d_rs2_en, d_imm_sel, d_alu_op, d_is_load, d_rd_wen;
    logic [4:0]  d_rs1_addr, d_rs2_addr, d_rd_waddr, w_rd_waddr;
    logic [31:0] d_rs1_data, d_rs2_data, d_imm, x_result, w_result;
    logic        w_val, w_rd_wen, x_stall, squash;
    logic        d_stall, x_val, x_alu_op, x_rd_wen, x_is_load;
    logic [31:0] x_in0, x_in1, x_sdata;
    logic [4:0]  x_rd_waddr;

    always #5 clk = ~clk;

    alu_operand_stage #(.NREG_BITS(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_val(d_val), .d_rs1_addr(d_rs1_addr), .d_rs2_addr(d_rs2_addr),
        .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en),
        .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
        .d_imm(d_imm), .d_imm_sel(d_imm_sel), .d_alu_op(d_alu_op),
        .d_is_load(d_is_load), .d_rd_waddr(d_rd_waddr), .d_rd_wen(d_rd_wen),
        .x_result(x_result), .w_val(w_val), .w_rd_waddr(w_rd_waddr),
        .w_rd_wen(w_rd_wen), .w_result(w_result),
        .x_stall(x_stall), .squash(squash), .d_stall(d_stall),
        .x_val(x_val), .x_in0(x_in0), .x_in1(x_in1), .x_alu_op(x_alu_op),
        .x_sdata(x_sdata), .x_rd_waddr(x_rd_waddr), .x_rd_wen(x_rd_wen),
        .x_is_load(x_is_load)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference view of the instruction sitting in X
    logic        m_val, m_op, m_wen, m_load;
    logic [31:0] m_in0, m_in1, m_sdata;
    logic [4:0]  m_rd;
    logic        last_dstall;

    task automatic m_reset();
        m_val = 0; m_op = 0; m_wen = 0; m_load = 0;
        m_in0 = 0; m_in1 = 0; m_sdata = 0; m_rd = 0;
    endtask

    // Value of register a as seen by D: youngest in-flight writer wins, x0 never forwarded
    function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        if (m_val && m_wen && !m_load && m_rd == a) return x_result;
        if (w_val && w_rd_wen && w_rd_waddr == a) return w_result;
        return rf;
    endfunction

    task automatic clear_inputs();
        d_val = 0; d_rs1_addr = 0; d_rs2_addr = 0; d_rs1_en = 0; d_rs2_en = 0;
        d_rs1_data = 0; d_rs2_data = 0; d_imm = 0; d_imm_sel = 0; d_alu_op = 0;
        d_is_load = 0; d_rd_waddr = 0; d_rd_wen = 0; x_result = 0;
        w_val = 0; w_rd_waddr = 0; w_rd_wen = 0; w_result = 0;
        x_stall = 0; squash = 0;
    endtask

    // Inputs are already driven; check d_stall, clock once, check X outputs
    task automatic step(input string tag);
        logic        uses_ld, e_stall;
        logic        n_val, n_op, n_wen, n_load;
        logic [31:0] n_in0, n_in1, n_sdata;
        logic [4:0]  n_rd;
        #2;
        uses_ld = d_val && m_val && m_load && m_wen && (m_rd != 0) &&
                  ((d_rs1_en && d_rs1_addr == m_rd) || (d_rs2_en && d_rs2_addr == m_rd));
        e_stall = x_stall || (!squash && uses_ld);
        last_dstall = d_stall;
        chk({tag, ".d_stall"}, 32'(d_stall), 32'(e_stall));
        n_val = m_val; n_op = m_op; n_wen = m_wen; n_load = m_load;
        n_in0 = m_in0; n_in1 = m_in1; n_sdata = m_sdata; n_rd = m_rd;
        if (!x_stall) begin
            if (squash || uses_ld) begin
                n_val = 0; n_wen = 0; n_load = 0;
            end else begin
                n_val   = d_val;
                n_in0   = ref_src(d_rs1_addr, d_rs1_data);
                n_sdata = ref_src(d_rs2_addr, d_rs2_data);
                n_in1   = d_imm_sel ? d_imm : n_sdata;
                n_op    = d_alu_op;
                n_rd    = d_rd_waddr;
                n_wen   = d_val && d_rd_wen;
                n_load  = d_val && d_is_load;
            end
        end
        @(posedge clk);
        #1;
        m_val = n_val; m_op = n_op; m_wen = n_wen; m_load = n_load;
        m_in0 = n_in0; m_in1 = n_in1; m_sdata = n_sdata; m_rd = n_rd;
        chk({tag, ".x_val"},     32'(x_val),     32'(m_val));
        chk({tag, ".x_rd_wen"},  32'(x_rd_wen),  32'(m_wen));
        chk({tag, ".x_is_load"}, 32'(x_is_load), 32'(m_load));
        if (m_val) begin
            chk({tag, ".x_in0"},      x_in0,             m_in0);
            chk({tag, ".x_in1"},      x_in1,             m_in1);
            chk({tag, ".x_sdata"},    x_sdata,           m_sdata);
            chk({tag, ".x_alu_op"},   32'(x_alu_op),     32'(m_op));
            chk({tag, ".x_rd_waddr"}, 32'(x_rd_waddr),   32'(m_rd));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".x_val"},      32'(x_val),      0);
        chk({tag, ".x_in0"},      x_in0,           0);
        chk({tag, ".x_in1"},      x_in1,           0);
        chk({tag, ".x_sdata"},    x_sdata,         0);
        chk({tag, ".x_alu_op"},   32'(x_alu_op),   0);
        chk({tag, ".x_rd_waddr"}, 32'(x_rd_waddr), 0);
        chk({tag, ".x_rd_wen"},   32'(x_rd_wen),   0);
        chk({tag, ".x_is_load"},  32'(x_is_load),  0);
    endtask

    typedef struct {
        logic        d_val;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2;
        logic        wen, load;
        logic [31:0] xres;
        logic        wval;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        e_stall, e_val;
        logic [31:0] e_in0, e_in1;
    } vec_t;

    function automatic vec_t mk(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [4:0] rd, input logic wen, input logic load,
                                input logic [31:0] xres, input logic wval,
                                input logic [4:0] wrd, input logic [31:0] wres,
                                input logic es, input logic ev,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.d_val = dv; v.rs1 = rs1; v.rs2 = rs2; v.rd1 = rd1; v.rd2 = rd2;
        v.rd = rd; v.wen = wen; v.load = load; v.xres = xres;
        v.wval = wval; v.wrd = wrd; v.wres = wres;
        v.e_stall = es; v.e_val = ev; v.e_in0 = e0; v.e_in1 = e1;
        return v;
    endfunction

    task automatic rand_inputs(input logic allow_ctrl);
        d_val      = ($urandom_range(0, 3) != 0);
        d_rs1_addr = 5'($urandom_range(0, 3));
        d_rs2_addr = 5'($urandom_range(0, 3));
        d_rs1_en   = 1'($urandom);
        d_rs2_en   = 1'($urandom);
        d_rs1_data = $urandom;
        d_rs2_data = $urandom;
        d_imm      = $urandom;
        d_imm_sel  = 1'($urandom);
        d_alu_op   = 1'($urandom);
        d_is_load  = ($urandom_range(0, 2) == 0);
        d_rd_waddr = 5'($urandom_range(0, 3));
        d_rd_wen   = 1'($urandom);
        x_result   = $urandom;
        w_val      = 1'($urandom);
        w_rd_waddr = 5'($urandom_range(0, 3));
        w_rd_wen   = 1'($urandom);
        w_result   = $urandom;
        x_stall    = allow_ctrl && ($urandom_range(0, 4) == 0);
        squash     = allow_ctrl && ($urandom_range(0, 4) == 0);
    endtask

    vec_t tbl[$];

    initial begin
        clear_inputs();
        m_reset();
        #12;
        chk_all_zero("reset");
        chk("reset.d_stall", 32'(d_stall), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //        dv rs1 rs2 rd1           rd2 rd wen ld xres          wv wrd wres          st v  in0           in1
        tbl.push_back(mk(1, 0, 0, 0,            0, 1, 1, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(1, 1, 1, 0,            0, 2, 1, 0, 32'h7,         0, 0, 32'h0,         0, 1, 32'h7,         32'h7));
        tbl.push_back(mk(1, 0, 0, 0,            0, 3, 1, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(1, 3, 0, 0,            0, 0, 0, 0, 32'hAAAA0000,  1, 3, 32'h0000BBBB,  0, 1, 32'hAAAA0000,  32'h0));
        tbl.push_back(mk(1, 3, 0, 32'h5555,     0, 0, 0, 0, 32'hAAAA0000,  1, 3, 32'h0000BBBB,  0, 1, 32'h0000BBBB,  32'h0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 5, 1, 1, 32'h0,         0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(1, 5, 0, 0,            0, 6, 1, 0, 32'hDEAD,      0, 0, 32'h0,         1, 0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 5, 0, 0,            0, 6, 1, 0, 32'hDEAD,      1, 5, 32'h12345678,  0, 1, 32'h12345678,  32'h0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0, 1, 1, 32'h1234,      0, 0, 32'h0,         0, 1, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 7, 1, 0, 32'h1234,      0, 0, 32'h0,         0, 1, 32'h0,         32'h0));

        foreach (tbl[i]) begin
            clear_inputs();
            d_val = tbl[i].d_val; d_rs1_en = 1; d_rs2_en = 1;
            d_rs1_addr = tbl[i].rs1; d_rs2_addr = tbl[i].rs2;
            d_rs1_data = tbl[i].rd1; d_rs2_data = tbl[i].rd2;
            d_rd_waddr = tbl[i].rd; d_rd_wen = tbl[i].wen; d_is_load = tbl[i].load;
            x_result = tbl[i].xres;
            w_val = tbl[i].wval; w_rd_wen = tbl[i].wval;
            w_rd_waddr = tbl[i].wrd; w_result = tbl[i].wres;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_stall", i), 32'(last_dstall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d.tbl_val", i),   32'(x_val),       32'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                chk($sformatf("vec%0d.tbl_in0", i), x_in0, tbl[i].e_in0);
                chk($sformatf("vec%0d.tbl_in1", i), x_in1, tbl[i].e_in1);
            end
        end

        // Hold X for three cycles while everything upstream churns, then squash
        clear_inputs();
        d_val = 1; d_rs1_data = 32'hCAFE0001; d_rs2_data = 32'hCAFE0002;
        d_rd_waddr = 5'd4; d_rd_wen = 1;
        step("hold.load");
        for (int k = 0; k < 3; k++) begin
            rand_inputs(1'b0);
            x_stall = 1;
            squash  = 1'($urandom);
            step($sformatf("hold%0d", k));
            chk($sformatf("hold%0d.stall", k), 32'(last_dstall), 1);
            chk($sformatf("hold%0d.val", k),   32'(x_val),       1);
            chk($sformatf("hold%0d.in0", k),   x_in0,            32'hCAFE0001);
            chk($sformatf("hold%0d.in1", k),   x_in1,            32'hCAFE0002);
            chk($sformatf("hold%0d.rd", k),    32'(x_rd_waddr),  4);
        end
        clear_inputs();
        d_val = 1; d_rd_waddr = 5'd8; d_rd_wen = 1; squash = 1;
        step("squash");
        chk("squash.stall", 32'(last_dstall), 0);
        chk("squash.val",   32'(x_val),       0);

        for (int k = 0; k < 300; k++) begin
            rand_inputs(1'b1);
            step($sformatf("rnd%0d", k));
        end

        // Asynchronous reset between clock edges
        clear_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_all_zero("areset");
        chk("areset.d_stall", 32'(d_stall), 0);
        #2;
        rst_n = 1'b1;
        d_val = 1; d_rs1_data = 32'h0BADF00D; d_rd_waddr = 5'd9; d_rd_wen = 1;
        step("post_reset");
        chk("post_reset.val", 32'(x_val), 1);
        chk("post_reset.in0", x_in0,      32'h0BADF00D);

        for (int k = 0; k < 100; k++) begin
            rand_inputs(1'b1);
            step($sformatf("rnd2_%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
